ssd_scanner: RTL and testbench
==============================

# ssd_scanner

Time-multiplexed four-digit seven-segment display driver that consumes the slow `divided` strobe produced by `ClockDivider` and uses it as its scan enable. It holds a 16-bit hexadecimal value (four nibbles), accepts new values through a valid/ready handshake and commits them only at frame boundaries so a frame never shows digits from two different values. It drives active-low anodes, segments and decimal points directly to the board pins.

## Interface
- `DIGITS`, 4: number of digits scanned; fixed at 4 for this revision.
- `BLANK_LEADING`, 1: when 1, leading-zero digits above the most significant nonzero digit are blanked.
- `clk` in 1: system clock, the same clock that drives `ClockDivider`.
- `rst_n` in 1: synchronous, active-low reset.
- `scan_en` in 1: level from `ClockDivider.divided`, synchronous to `clk`; each rising edge advances the scan by one digit.
- `value` in 16: hex value to display; nibble i is shown on digit i, and digit 0 is the rightmost.
- `value_valid` in 1: `value` and `dp_mask` are presented.
- `value_ready` out 1: the block can accept a value this cycle.
- `dp_mask` in 4: decimal point enables, one per digit, active high; captured together with `value`.
- `an` out 4: anodes, active low, one-hot-low while scanning.
- `seg` out 7: cathodes `{g,f,e,d,c,b,a}`, active low.
- `dp` out 1: decimal point cathode, active low.

## Operation
- Edge detect: `scan_q` holds the previous `scan_en`. A scan step occurs in any cycle where `scan_en`=1 and `scan_q`=0.
  - Holding `scan_en` high yields exactly one step.
- Digit index `idx` (2 bit) resets to 3. On each scan step, `idx` becomes `idx+1` mod 4. A step that takes `idx` to 0 is a frame boundary.
- The update buffer is a 2-state FSM.
  - EMPTY: `value_ready`=1. When `value_valid` is high, capture `value`/`dp_mask` into `pend_val`/`pend_dp` and go to FULL.
  - FULL: `value_ready`=0. At a frame boundary, copy the pending registers into `disp_val`/`disp_dp` and go to EMPTY.
- No bypass: a value accepted in the same cycle as a frame boundary is not committed at that boundary; it waits for the next one.
- Display: on a scan step, the outputs are registered from the new `idx`.
  - `an` = ~(1<<idx).
  - `seg` = decode(`disp_val[4*idx+:4]`), or blank (7'h7F) if the digit is a leading zero and `BLANK_LEADING`=1.
  - `dp` = ~`disp_dp[idx]`.
- Leading zero rule: a digit is a leading zero when it and all higher nibbles are 0. Digit 0 is never blanked, so a value of 0 shows a single "0".
- `disp_val` and `disp_dp` are used at frame commit and at each step. The outputs hold their values between steps.
- Decode patterns:
  - 0→1000000, 1→1111001, 2→0100100, 3→0110000
  - 4→0011001, 5→0010010, 6→0000010, 7→1111000
  - 8→0000000, 9→0010000, A→0001000, b→0000011
  - C→1000110, d→0100001, E→0000110, F→0001110

## Timing
- Reset values (applied at the first `clk` edge with `rst_n`=0):
  - `an`=4'b1111, `seg`=7'h7F, `dp`=1.
  - `idx`=3, `scan_q`=0, FSM=EMPTY, `value_ready`=1.
  - `disp_val`=0, `disp_dp`=0, pending registers=0.
- Reset has priority over every other event in the same cycle. Reset mid-frame or mid-handshake discards the pending value.
- Step latency: `an`/`seg`/`dp` change on the same clock edge at which the step condition is sampled. That is one cycle after `divided` rises.
- A handshake completes on the edge where `value_valid` and `value_ready` are both 1. `value_ready` falls on that same edge.
- Commit happens on the frame-boundary edge, and digit 0 shows the new value on that edge. `value_ready` rises on that edge.
- With `ClockDivider` ratio=10: one step per 10 clk cycles, and one frame per 40 cycles.
- First step after reset: `idx` 3→0 (a frame boundary). If a value is pending it is committed; otherwise the display shows 0.

## Structure
- Shared package `ssd_pkg` contains:
  - `DIGITS_P` = 4.
  - `SEG_BLANK` = 7'h7F.
  - The 16-entry hex segment pattern constant.
  - The FSM state typedef (`BUF_EMPTY`, `BUF_FULL`).
- Sub-module `hex_to_ssd`: combinational 4-bit to 7-bit active-low decoder, instantiated once on the selected nibble.
- Top-level contents: edge detect, index counter, buffer FSM, leading-zero logic, output registers.

## Test plan
- Reset, no input, `scan_en` from `ClockDivider` (ratio 10): outputs stay at 1111/7F/1 until the first step. Then `an`=1110, `seg`=1000000, and digits 1–3 are blanked with `seg`=7F.
- Accept 16'h12AF with `dp_mask`=4'b0100: `value_ready` drops for one frame. After the next boundary, digits 0..3 show F, A, 2, 1. `dp`=0 only while `an`=1011.
- `value_valid` held through FULL with a changing `value`: only the first value is captured and displayed. The next value is accepted on the cycle after `value_ready` returns to 1.
- Accept 16'h0034 in the same cycle as a frame boundary: it is not displayed during that frame and is committed at the following boundary. Digits 2 and 3 are blanked.
- Hold `scan_en`=1 for 25 cycles: exactly one step. Then apply `rst_n`=0 for one cycle mid-frame with a value pending: reset values are restored and the pending value is lost.

Source files
------------

// File: rtl/ssd_pkg.sv
// Shared types and constants for the four-digit seven-segment scanner.
package ssd_pkg;

  localparam int DIGITS_P = 4;
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  // Active-low {g,f,e,d,c,b,a} patterns for hex digits 0..F
  localparam logic [6:0] HEX_SEG [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  typedef enum logic {BUF_EMPTY, BUF_FULL} buf_state_t;

endpackage

// File: rtl/hex_to_ssd.sv
// Combinational hex nibble to active-low seven-segment pattern decoder.
module hex_to_ssd
  import ssd_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  assign seg = HEX_SEG[nib];

endmodule

// File: rtl/ssd_scanner.sv
// Four-digit multiplexed seven-segment driver with frame-synchronous value
// updates through a one-deep valid/ready buffer.
module ssd_scanner
  import ssd_pkg::*;
#(
  parameter int DIGITS        = DIGITS_P,
  parameter bit BLANK_LEADING = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  scan_en,
  input  logic [4*DIGITS-1:0]   value,
  input  logic                  value_valid,
  output logic                  value_ready,
  input  logic [DIGITS-1:0]     dp_mask,
  output logic [DIGITS-1:0]     an,
  output logic [6:0]            seg,
  output logic                  dp
);

  localparam int IW = $clog2(DIGITS);

  logic                scan_q;
  logic [IW-1:0]       idx;
  logic [IW-1:0]       idx_nxt;
  buf_state_t          state;
  logic [4*DIGITS-1:0] pend_val;
  logic [DIGITS-1:0]   pend_dp;
  logic [4*DIGITS-1:0] disp_val;
  logic [DIGITS-1:0]   disp_dp;
  logic                step;
  logic                frame_bnd;
  logic                commit;
  logic [4*DIGITS-1:0] cur_val;
  logic [DIGITS-1:0]   cur_dp;
  logic [3:0]          nib;
  logic [6:0]          seg_dec;

  // True when digit i and every higher nibble are zero; digit 0 never blanks.
  function automatic logic is_lead_zero(input logic [4*DIGITS-1:0] v,
                                        input logic [IW-1:0] i);
    logic z;
    z = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      if (k >= int'(i) && v[4*k +: 4] != 4'h0) z = 1'b0;
    end
    return z && (i != '0);
  endfunction

  assign step      = scan_en && !scan_q;
  assign idx_nxt   = idx + 1'b1;
  assign frame_bnd = step && (idx_nxt == '0);
  assign commit    = frame_bnd && (state == BUF_FULL);

  // Digit 0 must show a freshly committed value on the commit edge itself.
  assign cur_val = commit ? pend_val : disp_val;
  assign cur_dp  = commit ? pend_dp  : disp_dp;
  assign nib     = cur_val[4*idx_nxt +: 4];

  assign value_ready = (state == BUF_EMPTY);

  hex_to_ssd u_dec (
    .nib (nib),
    .seg (seg_dec)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      scan_q   <= 1'b0;
      idx      <= IW'(DIGITS - 1);
      state    <= BUF_EMPTY;
      pend_val <= '0;
      pend_dp  <= '0;
      disp_val <= '0;
      disp_dp  <= '0;
      an       <= '1;
      seg      <= SEG_BLANK;
      dp       <= 1'b1;
    end else begin
      scan_q <= scan_en;

      // A value accepted on a boundary edge waits for the next boundary.
      case (state)
        BUF_EMPTY: begin
          if (value_valid) begin
            pend_val <= value;
            pend_dp  <= dp_mask;
            state    <= BUF_FULL;
          end
        end
        BUF_FULL: begin
          if (frame_bnd) begin
            disp_val <= pend_val;
            disp_dp  <= pend_dp;
            state    <= BUF_EMPTY;
          end
        end
        default: state <= BUF_EMPTY;
      endcase

      if (step) begin
        idx <= idx_nxt;
        an  <= ~({{(DIGITS-1){1'b0}}, 1'b1} << idx_nxt);
        seg <= (BLANK_LEADING && is_lead_zero(cur_val, idx_nxt)) ? SEG_BLANK : seg_dec;
        dp  <= ~cur_dp[idx_nxt];
      end
    end
  end

endmodule

// File: tb/tb_ssd_scanner.sv
// Scoreboard bench for ssd_scanner: a cycle model pushes expected outputs,
// which are popped and compared one edge later.
module tb_ssd_scanner;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        scan_en;
  logic [15:0] value;
  logic        value_valid;
  logic        value_ready;
  logic [3:0]  dp_mask;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic        dp;

  ssd_scanner #(.DIGITS(4), .BLANK_LEADING(1'b1)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .scan_en     (scan_en),
    .value       (value),
    .value_valid (value_valid),
    .value_ready (value_ready),
    .dp_mask     (dp_mask),
    .an          (an),
    .seg         (seg),
    .dp          (dp)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] TB_HEX [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  int errors = 0;
  int checks = 0;

  // model state
  logic        m_scan_q;
  logic [1:0]  m_idx;
  logic        m_full;
  logic [15:0] m_pend, m_disp;
  logic [3:0]  m_pdp, m_ddp;
  logic [3:0]  m_an;
  logic [6:0]  m_seg;
  logic        m_dp;

  logic [12:0] exp_q [$];
  int          div_cnt = 0;
  logic        ovr = 1'b0;
  logic        ovr_val = 1'b0;
  logic [6:0]  obs_seg [4];
  logic        obs_dp [4];
  logic [3:0]  prev_an = 4'hF;
  int          an_changes = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic tick();
    logic        stp, bnd, stepped;
    logic [1:0]  ni, sidx;
    logic [15:0] nd;
    logic [3:0]  ndp;
    logic [12:0] e;
    scan_en = ovr ? ovr_val : ((div_cnt % 10) >= 5);
    stepped = 1'b0;
    sidx    = 2'd0;
    if (!rst_n) begin
      m_scan_q = 1'b0; m_idx = 2'd3; m_full = 1'b0;
      m_pend = '0; m_pdp = '0; m_disp = '0; m_ddp = '0;
      m_an = 4'hF; m_seg = 7'h7F; m_dp = 1'b1;
    end else begin
      stp = scan_en && !m_scan_q;
      ni  = m_idx + 2'd1;
      bnd = stp && (ni == 2'd0);
      nd  = m_disp;
      ndp = m_ddp;
      if (m_full && bnd) begin
        nd  = m_pend;
        ndp = m_pdp;
      end
      if (stp) begin
        m_an  = ~(4'b0001 << ni);
        m_seg = (ni != 2'd0 && (nd >> (4 * ni)) == 16'h0) ? 7'h7F : TB_HEX[nd[4*ni +: 4]];
        m_dp  = ~ndp[ni];
        m_idx = ni;
        stepped = 1'b1;
        sidx = ni;
      end
      if (!m_full && value_valid) begin
        m_pend = value; m_pdp = dp_mask; m_full = 1'b1;
      end else if (m_full && bnd) begin
        m_disp = nd; m_ddp = ndp; m_full = 1'b0;
      end
      m_scan_q = scan_en;
    end
    exp_q.push_back({m_an, m_seg, m_dp, ~m_full});
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    check_val("disp", {20'h0, an, seg, dp}, {20'h0, e[12:1]});
    check_val("ready", {31'h0, value_ready}, {31'h0, e[0]});
    if (stepped) begin
      obs_seg[sidx] = seg;
      obs_dp[sidx]  = dp;
    end
    if (an != prev_an) an_changes++;
    prev_an = an;
    div_cnt++;
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_frame(input string tag, input logic [6:0] s0, input logic [6:0] s1,
                             input logic [6:0] s2, input logic [6:0] s3);
    check_val({tag, "_d0"}, {25'h0, obs_seg[0]}, {25'h0, s0});
    check_val({tag, "_d1"}, {25'h0, obs_seg[1]}, {25'h0, s1});
    check_val({tag, "_d2"}, {25'h0, obs_seg[2]}, {25'h0, s2});
    check_val({tag, "_d3"}, {25'h0, obs_seg[3]}, {25'h0, s3});
  endtask

  initial begin
    int n;
    rst_n = 1'b0; scan_en = 1'b0; value = '0; value_valid = 1'b0; dp_mask = '0;
    for (int i = 0; i < 4; i++) begin
      obs_seg[i] = 7'h00;
      obs_dp[i]  = 1'b0;
    end

    // reset state
    run(2);
    check_val("rst_an", {28'h0, an}, 32'hF);
    check_val("rst_seg", {25'h0, seg}, 32'h7F);
    check_val("rst_dp", {31'h0, dp}, 32'h1);
    check_val("rst_ready", {31'h0, value_ready}, 32'h1);
    rst_n = 1'b1;

    // idle display of zero: single "0", upper digits blank
    run(45);
    check_frame("zero", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);

    // 12AF with dp on digit 2
    value = 16'h12AF; dp_mask = 4'b0100; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    check_val("acc_ready_low", {31'h0, value_ready}, 32'h0);
    run(90);
    check_frame("h12af", 7'b0001110, 7'b0001000, 7'b0100100, 7'b1111001);
    check_val("dp_d0", {31'h0, obs_dp[0]}, 32'h1);
    check_val("dp_d1", {31'h0, obs_dp[1]}, 32'h1);
    check_val("dp_d2", {31'h0, obs_dp[2]}, 32'h0);
    check_val("dp_d3", {31'h0, obs_dp[3]}, 32'h1);

    // valid held through FULL with changing value
    dp_mask = 4'b0000; value = 16'h1111; value_valid = 1'b1;
    tick();
    n = 0;
    while (m_full && n < 100) begin
      value = 16'($urandom);
      tick();
      n++;
    end
    check_val("held_bound", {31'h0, n < 100}, 32'h1);
    value = 16'hCDE9;
    tick();
    value_valid = 1'b0;
    run(90);
    check_frame("hcde9", 7'b0010000, 7'b0000110, 7'b0100001, 7'b1000110);

    // accept 0034 on a frame-boundary edge
    n = 0;
    while (!(((div_cnt % 10) >= 5) && !m_scan_q && m_idx == 2'd3) && n < 200) begin
      tick();
      n++;
    end
    check_val("bnd_bound", {31'h0, n < 200}, 32'h1);
    value = 16'h0034; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    check_val("no_bypass_d0", {25'h0, obs_seg[0]}, {25'h0, 7'b0010000});
    run(80);
    check_frame("h0034", 7'b0011001, 7'b0110000, 7'h7F, 7'h7F);

    // scan_en held high: one step only
    ovr = 1'b1; ovr_val = 1'b0;
    tick();
    ovr_val = 1'b1;
    an_changes = 0;
    run(25);
    check_val("hold_steps", an_changes, 32'd1);
    ovr_val = 1'b0;
    tick();
    ovr = 1'b0;

    // reset with a value pending discards it
    value = 16'hFFFF; dp_mask = 4'hF; value_valid = 1'b1;
    tick();
    value_valid = 1'b0;
    check_val("pending", {31'h0, value_ready}, 32'h0);
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check_val("rst2_an", {28'h0, an}, 32'hF);
    check_val("rst2_seg", {25'h0, seg}, 32'h7F);
    check_val("rst2_dp", {31'h0, dp}, 32'h1);
    check_val("rst2_ready", {31'h0, value_ready}, 32'h1);
    run(45);
    check_frame("post_rst", 7'b1000000, 7'h7F, 7'h7F, 7'h7F);
    check_val("post_rst_dp0", {31'h0, obs_dp[0]}, 32'h1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
